interconnect_arbiter: RTL and testbench
=======================================

Name: interconnect_arbiter

Overview:
- Round-robin arbiter that shares one registered N-input word mux (`sel` register followed by an output register, 2-cycle latency) between N_INPUTS requesters.
- Grants one requester at a time for a burst of `burst_len` words and drives the mux `sel`.
- Emits `valid`, `chan` and `last` delayed so they align exactly with the mux output word.
- Sits beside the mux in the acquisition fabric; downstream logic qualifies mux `out` with `valid` and `chan`.

Parameters:
- N_INPUTS, 3, number of requesters and mux inputs (2..16).
- SEL_WIDTH, 2, width of `sel` and `chan`; must satisfy 2^SEL_WIDTH >= N_INPUTS.
- MUX_LATENCY, 2, cycles from a `sel` change to the matching word on mux `out` (>= 1).
- LEN_WIDTH, 16, width of `burst_len`.

Ports:
- clk        input   1            clock, all logic on rising edge
- rst        input   1            synchronous active-high reset
- req        input   N_INPUTS     per-requester request level
- burst_len  input   LEN_WIDTH    words per grant, sampled at grant
- sel        output  SEL_WIDTH    drives the mux `sel`
- grant      output  N_INPUTS     one-hot current grant (all-zero when idle)
- busy       output  1            high while a burst is being issued
- valid      output  1            mux `out` holds a granted word this cycle
- chan       output  SEL_WIDTH    requester index of the word on mux `out`
- last       output  1            final word of the burst on mux `out`

Behaviour:
- Reset values (1 cycle after `rst` high):
  - `sel` = 0, `grant` = 0, `busy` = 0, `valid` = 0, `chan` = 0, `last` = 0.
  - RR pointer = N_INPUTS-1, so requester 0 is searched first.
  - Delay pipeline cleared.
- FSM states:
  - IDLE: no grant. If any `req` bit is high, arbitrate.
    - Next cycle: state = STREAM, `sel` = winner, `grant` = onehot(winner), `busy` = 1, word counter = `burst_len` (0 treated as 1), RR pointer = winner.
  - STREAM: an internal strobe is high every cycle. Word counter decrements each cycle; internal `last` is high when counter = 1.
    - On the internal-last cycle, arbitrate again using that cycle's `req`.
    - If a winner exists: next cycle starts its burst with no bubble.
    - Otherwise: next cycle returns to IDLE (`grant` = 0, `busy` = 0; `sel` holds its last value).
- Arbitration:
  - Search starts at pointer+1 mod N_INPUTS and wraps.
  - The first set `req` bit wins.
  - If only the previously granted requester is requesting, it wins again.
- `req` is sampled only at arbitration points. Deasserting `req` mid-burst does not shorten the burst. `burst_len` changes mid-burst have no effect.
- Output alignment:
  - Internal strobe, `sel` and internal `last` pass through a MUX_LATENCY-deep register chain, producing `valid`, `chan` and `last`.
  - A word issued with `sel` = k in cycle t appears as `valid` = 1, `chan` = k in cycle t+MUX_LATENCY.
  - Back-to-back bursts therefore give a gap-free `valid` stream.
- Reset mid-burst: the burst is aborted, the pipeline is flushed, and `valid` is 0 from the cycle after `rst`. Words still inside the mux are discarded (`valid` is low for them).
- `req` bits at index >= N_INPUTS do not exist. `sel` never exceeds N_INPUTS-1.

Optional Feature:
- Macro: INTERCONNECT_ARB_PRIO0_EN.
- Defined: at every arbitration point `req[0]` wins whenever set, regardless of the RR pointer. The other requesters rotate round-robin among themselves. The pointer is updated only by non-0 grants.
- Undefined: pure round-robin over all inputs. No extra logic is generated.

Test Plan:
- Single request: reset, `burst_len` = 4, `req` = 3'b010 at cycle 0 -> cycle 1: `sel` = 1, `grant` = 3'b010, `busy` = 1. `valid` high cycles 3-6 with `chan` = 1, `last` only at cycle 6. `busy` low from cycle 5, `valid` low from cycle 7.
- Round robin, all requesting: `req` = 3'b111 held, `burst_len` = 2 -> grant order 0,1,2,0,… with no idle cycle between bursts. `valid` stays continuously high once the pipeline is filled. `chan` sequence 0,0,1,1,2,2,…
- `burst_len` = 0 with `req[2]` -> exactly one word: `valid` for 1 cycle with `chan` = 2 and `last` = 1.
- Request drop mid-burst: `burst_len` = 8, `req[0]` deasserted after 2 words -> all 8 words still issued, then IDLE.
- Reset mid-burst: assert `rst` for 1 cycle during word 3 of 6 -> every output is 0 from the next cycle. First grant after reset goes to the lowest set `req` bit.
- With INTERCONNECT_ARB_PRIO0_EN defined: `req` = 3'b111 held, `burst_len` = 1 -> `chan` sequence 0,0,0,…. Then `req[0]` dropped -> sequence alternates 1,2,1,2.

Source files
------------

// File: rtl/interconnect_arbiter.sv
// interconnect_arbiter: round-robin burst arbiter driving a registered word mux; optional INTERCONNECT_ARB_PRIO0_EN gives req[0] absolute priority
module interconnect_arbiter #(
  parameter int N_INPUTS    = 3,
  parameter int SEL_WIDTH   = 2,
  parameter int MUX_LATENCY = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_INPUTS-1:0]  req,
  input  logic [LEN_WIDTH-1:0] burst_len,
  output logic [SEL_WIDTH-1:0] sel,
  output logic [N_INPUTS-1:0]  grant,
  output logic                 busy,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] chan,
  output logic                 last
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [LEN_WIDTH-1:0] cnt, cnt_n;
  logic [SEL_WIDTH-1:0] ptr, ptr_n, sel_n, win;
  logic [N_INPUTS-1:0] grant_n, rot;
  logic found, strobe, int_last, arb, take, ptr_upd;
  logic [MUX_LATENCY-1:0] v_pipe, l_pipe;
  logic [SEL_WIDTH-1:0] c_pipe [MUX_LATENCY];
  int sum;
  // rot[j] is req[(ptr+1+j) mod N]; scanning high to low leaves the first hit in win
  always_comb begin
    rot = N_INPUTS'({req, req} >> (int'(ptr) + 1));
    win = '0;
    sum = 0;
    found = |req;
    for (int j = N_INPUTS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = int'(ptr) + 1 + j;
        win = SEL_WIDTH'(sum >= N_INPUTS ? sum - N_INPUTS : sum);
      end
    end
`ifdef INTERCONNECT_ARB_PRIO0_EN
    if (req[0]) win = '0;
    ptr_upd = win != '0;
`else
    ptr_upd = 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= SEL_WIDTH'(N_INPUTS - 1);
      sel   <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      grant <= grant_n;
    end
  end
  always_comb begin
    arb     = (state == IDLE) ? |req : int_last;
    take    = arb && found;
    state_n = arb ? (found ? STREAM : IDLE) : state;
    cnt_n   = take ? (burst_len == '0 ? LEN_WIDTH'(1) : burst_len) : (strobe ? cnt - LEN_WIDTH'(1) : cnt);
    sel_n   = take ? win : sel;
    grant_n = take ? N_INPUTS'(1) << win : (arb ? '0 : grant);
    ptr_n   = (take && ptr_upd) ? win : ptr;
  end
  always_comb begin
    strobe   = state == STREAM;
    int_last = strobe && cnt == LEN_WIDTH'(1);
    busy     = strobe;
    valid    = v_pipe[MUX_LATENCY-1];
    last     = l_pipe[MUX_LATENCY-1];
    chan     = c_pipe[MUX_LATENCY-1];
  end
  // delay chain matching the mux latency so flags line up with mux out
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      l_pipe <= '0;
      for (int i = 0; i < MUX_LATENCY; i++) c_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= strobe;
      l_pipe[0] <= int_last;
      c_pipe[0] <= sel;
      for (int i = 1; i < MUX_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
    end
  end
endmodule

// File: tb/tb_interconnect_arbiter.sv
// tb_interconnect_arbiter: directed self-checking bench for interconnect_arbiter
module tb_interconnect_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] req = '0;
  logic [15:0] burst_len = '0;
  logic [1:0] sel, chan;
  logic [2:0] grant;
  logic busy, valid, last;
  int checks = 0;
  int errors = 0;
  int vcount;
  interconnect_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .burst_len(burst_len), .sel(sel),
    .grant(grant), .busy(busy), .valid(valid), .chan(chan), .last(last)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int exp_rr [10];
    int exp_pr [7];
    exp_rr = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
`ifdef INTERCONNECT_ARB_PRIO0_EN
    exp_pr = '{0, 0, 0, 0, 1, 2, 1};
`else
    exp_pr = '{0, 1, 2, 0, 1, 2, 1};
`endif
    tick();
    do_reset();
    chk("rst sel", sel, 0);
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    chk("rst valid", valid, 0);
    chk("rst chan", chan, 0);
    chk("rst last", last, 0);
    // single request, 4-word burst
    burst_len = 16'd4;
    req = 3'b010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        chk("t1 sel", sel, 1);
        chk("t1 grant", grant, 3'b010);
        req = 3'b000;
      end
      chk($sformatf("t1 busy c%0d", c), busy, c <= 4);
      chk($sformatf("t1 valid c%0d", c), valid, c >= 3 && c <= 6);
      chk($sformatf("t1 last c%0d", c), last, c == 6);
      if (c >= 3 && c <= 6) chk($sformatf("t1 chan c%0d", c), chan, 1);
    end
    chk("t1 grant idle", grant, 0);
    // round robin with all requesting, 2-word bursts
    rst = 1'b1;
    req = 3'b111;
    burst_len = 16'd2;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("t2 sel c%0d", c), sel, exp_rr[c-1]);
      chk($sformatf("t2 busy c%0d", c), busy, 1);
      chk($sformatf("t2 valid c%0d", c), valid, c >= 3);
      if (c >= 3) begin
        chk($sformatf("t2 chan c%0d", c), chan, exp_rr[c-3]);
        chk($sformatf("t2 last c%0d", c), last, c % 2 == 0);
      end
    end
    // zero burst length gives one word
    do_reset();
    req = 3'b100;
    burst_len = 16'd0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        chk("t3 sel", sel, 2);
        chk("t3 grant", grant, 3'b100);
        req = 3'b000;
      end
      chk($sformatf("t3 busy c%0d", c), busy, c == 1);
      chk($sformatf("t3 valid c%0d", c), valid, c == 3);
      chk($sformatf("t3 last c%0d", c), last, c == 3);
      if (c == 3) chk("t3 chan", chan, 2);
    end
    // request dropped mid-burst keeps full length
    do_reset();
    req = 3'b001;
    burst_len = 16'd8;
    vcount = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) chk("t4 grant", grant, 3'b001);
      if (c == 2) req = 3'b000;
      if (valid) vcount++;
      chk($sformatf("t4 busy c%0d", c), busy, c <= 8);
      chk($sformatf("t4 last c%0d", c), last, c == 10);
    end
    chk("t4 words", vcount, 8);
    // reset during word 3 of 6
    do_reset();
    req = 3'b001;
    burst_len = 16'd6;
    tick();
    tick();
    tick();
    chk("t5 busy pre", busy, 1);
    rst = 1'b1;
    req = 3'b110;
    tick();
    rst = 1'b0;
    chk("t5 sel", sel, 0);
    chk("t5 grant", grant, 0);
    chk("t5 busy", busy, 0);
    chk("t5 valid", valid, 0);
    chk("t5 chan", chan, 0);
    chk("t5 last", last, 0);
    tick();
    chk("t5 regrant sel", sel, 1);
    chk("t5 regrant grant", grant, 3'b010);
    chk("t5 flushed valid", valid, 0);
    tick();
    chk("t5 flushed valid2", valid, 0);
    // single-word bursts, then req[0] dropped
    rst = 1'b1;
    req = 3'b111;
    burst_len = 16'd1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("t6 sel c%0d", c), sel, exp_pr[c-1]);
      if (c >= 3) begin
        chk($sformatf("t6 valid c%0d", c), valid, 1);
        chk($sformatf("t6 chan c%0d", c), chan, exp_pr[c-3]);
        chk($sformatf("t6 last c%0d", c), last, 1);
      end
      if (c == 4) req = 3'b110;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
